regfile_mp: RTL and testbench

- Parametrised successor to the core's single-write register file.
- Two write ports with byte strobes and fixed priority.
- Two asynchronous read ports with optional same-cycle write-to-read bypass.
- Per-register pending scoreboard for hazard detection, plus a sequenced clear engine (req/busy/done) so software and debug can zero the file without a global reset.
- Sits in the decode/writeback stage of the pipelined core; write port 0 is ALU writeback, write port 1 is load/MMIO writeback.

---
 rtl/regfile_mp.sv | 171 +++++++++++++++++
 tb/tb_regfile_mp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// regfile_mp : dual-write / dual-read register file with byte strobes,
//              pending-producer scoreboard and sequenced clear engine. Rev 1.0
// ============================================================================
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   waddr0,
  input  logic [XLEN-1:0]     wdata0,
  input  logic [XLEN/8-1:0]   wstrb0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   waddr1,
  input  logic [XLEN-1:0]     wdata1,
  input  logic [XLEN/8-1:0]   wstrb1,
  input  logic [ADDR_W-1:0]   raddr1,
  input  logic [ADDR_W-1:0]   raddr2,
  output logic [XLEN-1:0]     rdata1,
  output logic [XLEN-1:0]     rdata2,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_addr,
  output logic                busy1,
  output logic                busy2,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic                clear_done
);

  localparam int                NBYTES   = XLEN / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [XLEN-1:0]     mem_q [NUM_REGS];
  logic [XLEN-1:0]     mem_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;

  // in_rng bit order: {issue, raddr2, raddr1, waddr1, waddr0}
  logic [4:0] in_rng;

  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_pow2
      assign in_rng = 5'b11111;
    end else begin : g_partial
      assign in_rng[0] = (32'(waddr0)     < NUM_REGS);
      assign in_rng[1] = (32'(waddr1)     < NUM_REGS);
      assign in_rng[2] = (32'(raddr1)     < NUM_REGS);
      assign in_rng[3] = (32'(raddr2)     < NUM_REGS);
      assign in_rng[4] = (32'(issue_addr) < NUM_REGS);
    end
  endgenerate

  logic sweeping;
  logic w0_ok, w1_ok, r1_ok, r2_ok, iss_ok;

  assign sweeping = (state_q == ST_SWEEP);
  assign w0_ok  = we0 && !sweeping && in_rng[0] && !(ZERO_REG && waddr0 == '0);
  assign w1_ok  = we1 && !sweeping && in_rng[1] && !(ZERO_REG && waddr1 == '0);
  assign r1_ok  = in_rng[2] && !(ZERO_REG && raddr1 == '0);
  assign r2_ok  = in_rng[3] && !(ZERO_REG && raddr2 == '0);
  assign iss_ok = issue_valid && !sweeping && in_rng[4] && !(ZERO_REG && issue_addr == '0);

  // Port 0 bytes land first, port 1 overrides on overlapping bytes.
  function automatic logic [XLEN-1:0] merge_wr(
    input logic [XLEN-1:0]   base,
    input logic [ADDR_W-1:0] a,
    input logic              e0,
    input logic [ADDR_W-1:0] a0,
    input logic [XLEN-1:0]   d0,
    input logic [NBYTES-1:0] s0,
    input logic              e1,
    input logic [ADDR_W-1:0] a1,
    input logic [XLEN-1:0]   d1,
    input logic [NBYTES-1:0] s1
  );
    logic [XLEN-1:0] v;
    v = base;
    for (int b = 0; b < NBYTES; b++) begin
      if (e0 && a0 == a && s0[b]) v[8*b +: 8] = d0[8*b +: 8];
      if (e1 && a1 == a && s1[b]) v[8*b +: 8] = d1[8*b +: 8];
    end
    return v;
  endfunction

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (reset_n && r1_ok)
      rdata1 = merge_wr(mem_q[raddr1], raddr1, BYPASS && w0_ok, waddr0, wdata0, wstrb0,
                        BYPASS && w1_ok, waddr1, wdata1, wstrb1);
    if (reset_n && r2_ok)
      rdata2 = merge_wr(mem_q[raddr2], raddr2, BYPASS && w0_ok, waddr0, wdata0, wstrb0,
                        BYPASS && w1_ok, waddr1, wdata1, wstrb1);
  end

  assign busy1 = r1_ok && pend_q[raddr1];
  assign busy2 = r2_ok && pend_q[raddr2];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    mem_d      = mem_q;
    pend_d     = pend_q;
    clear_busy = 1'b0;
    clear_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_SWEEP;
          ptr_d   = '0;
        end
      end
      ST_SWEEP: begin
        clear_busy     = 1'b1;
        mem_d[ptr_q]   = '0;
        pend_d[ptr_q]  = 1'b0;
        ptr_d          = ptr_q + 1'b1;
        if (ptr_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        clear_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // w*_ok / iss_ok are already false during a sweep.
    if (w0_ok) begin
      for (int b = 0; b < NBYTES; b++)
        if (wstrb0[b]) mem_d[waddr0][8*b +: 8] = wdata0[8*b +: 8];
      if (|wstrb0) pend_d[waddr0] = 1'b0;
    end
    if (w1_ok) begin
      for (int b = 0; b < NBYTES; b++)
        if (wstrb1[b]) mem_d[waddr1][8*b +: 8] = wdata1[8*b +: 8];
      if (|wstrb1) pend_d[waddr1] = 1'b0;
    end
    // A new producer issued alongside a retiring write keeps the register pending.
    if (iss_ok) pend_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      pend_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      mem_q   <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_regfile_mp : directed self-checking bench for regfile_mp. Rev 1.0
// ============================================================================
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        we0, we1, issue_valid, clear_req;
  logic [4:0]  waddr0, waddr1, raddr1, raddr2, issue_addr;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  wstrb0, wstrb1;
  logic [31:0] rdata1, rdata2, nb_rdata1, nb_rdata2;
  logic        busy1, busy2, clear_busy, clear_done;
  logic        nb_busy1, nb_busy2, nb_clear_busy, nb_clear_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wstrb0(wstrb0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wstrb1(wstrb1),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy1(busy1), .busy2(busy2),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  regfile_mp #(.XLEN(32), .NUM_REGS(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wstrb0(wstrb0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wstrb1(wstrb1),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .busy1(nb_busy1), .busy2(nb_busy2),
    .clear_req(clear_req), .clear_busy(nb_clear_busy), .clear_done(nb_clear_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we0 = 1'b0; we1 = 1'b0; issue_valid = 1'b0; clear_req = 1'b0;
    wstrb0 = '0; wstrb1 = '0;
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we0 = 1'b1; waddr0 = a; wdata0 = d; wstrb0 = s;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    we1 = 1'b1; waddr1 = a; wdata1 = d; wstrb1 = s;
  endtask

  // Request edge counts as cycle 0; SWEEP spans cycles 1..32, done pulse in 33.
  task automatic sweep_run(input bit noise);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      if (noise && k == 5) begin
        wr0(5'd2, 32'hFFFF_FFFF, 4'hF);
        issue_valid = 1'b1; issue_addr = 5'd2;
        clear_req = 1'b1;
        raddr1 = 5'd31; raddr2 = 5'd2;
      end
      if (noise && k == 33) clear_req = 1'b1;
      #1;
      chk("sweep_busy", {31'd0, clear_busy}, {31'd0, (k <= 32)});
      chk("sweep_done", {31'd0, clear_done}, {31'd0, (k == 33)});
      if (noise && k == 5) begin
        chk("sweep_live_read", rdata1, 32'd31);
        chk("sweep_no_bypass", rdata2, 32'd0);
      end
      tick();
      idle_in();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    idle_in();
    waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
    raddr1 = '0; raddr2 = '0; issue_addr = '0;
    tick();
    tick();

    // Reset state, including bypass gated off while reset is held.
    wr0(5'd5, 32'hDEAD_BEEF, 4'hF);
    raddr1 = 5'd5;
    #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    chk("rst_clear_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_clear_done", {31'd0, clear_done}, 32'd0);
    idle_in();
    tick();
    reset_n = 1'b1;
    tick();

    // Full write, bypass vs registered visibility.
    wr0(5'd5, 32'hDEAD_BEEF, 4'hF);
    raddr1 = 5'd5;
    #1;
    chk("byp_same_cycle", rdata1, 32'hDEAD_BEEF);
    chk("nobyp_same_cycle", nb_rdata1, 32'h0);
    tick();
    idle_in();
    #1;
    chk("wr_next_cycle", rdata1, 32'hDEAD_BEEF);
    chk("nobyp_next_cycle", nb_rdata1, 32'hDEAD_BEEF);

    // Same-index collision merge.
    wr1(5'd7, 32'h1122_3344, 4'hF);
    tick();
    idle_in();
    wr0(5'd7, 32'hAAAA_AAAA, 4'h3);
    wr1(5'd7, 32'hBBBB_BBBB, 4'h6);
    raddr2 = 5'd7;
    #1;
    chk("collide_bypass", rdata2, 32'h11BB_BBAA);
    tick();
    idle_in();
    #1;
    chk("collide_stored", nb_rdata2, 32'h11BB_BBAA);
    chk("collide_stored_byp", rdata2, 32'h11BB_BBAA);

    // Register 0 is hard-wired.
    wr0(5'd0, 32'hFFFF_FFFF, 4'hF);
    issue_valid = 1'b1; issue_addr = 5'd0;
    raddr1 = 5'd0;
    #1;
    chk("zero_same_cycle", rdata1, 32'h0);
    tick();
    idle_in();
    #1;
    chk("zero_after", rdata1, 32'h0);
    chk("zero_busy", {31'd0, busy1}, 32'd0);

    wr0(5'd3, 32'h3333_3333, 4'hF);
    raddr2 = 5'd3;
    #1;
    chk("nobyp_old_val", nb_rdata2, 32'h0);
    chk("byp_idx3", rdata2, 32'h3333_3333);
    tick();
    idle_in();
    #1;
    chk("nobyp_new_val", nb_rdata2, 32'h3333_3333);

    // Scoreboard.
    issue_valid = 1'b1; issue_addr = 5'd9; raddr1 = 5'd9;
    #1;
    chk("busy_not_bypassed", {31'd0, busy1}, 32'd0);
    tick();
    idle_in();
    #1;
    chk("busy_after_issue", {31'd0, busy1}, 32'd1);
    wr0(5'd9, 32'h0000_0055, 4'h0);
    tick();
    idle_in();
    #1;
    chk("busy_strb_zero", {31'd0, busy1}, 32'd1);
    wr0(5'd9, 32'h0000_0055, 4'h1);
    tick();
    idle_in();
    #1;
    chk("busy_cleared", {31'd0, busy1}, 32'd0);
    chk("byte0_write", rdata1, 32'h0000_0055);
    wr0(5'd9, 32'h0000_0077, 4'hF);
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    idle_in();
    #1;
    chk("issue_beats_write", {31'd0, busy1}, 32'd1);

    // Fill, mark one pending, sweep with dropped traffic.
    for (int i = 1; i < 32; i++) begin
      wr0(5'(i), 32'(i), 4'hF);
      tick();
    end
    idle_in();
    issue_valid = 1'b1; issue_addr = 5'd4;
    tick();
    idle_in();
    raddr1 = 5'd4; raddr2 = 5'd17;
    #1;
    chk("fill_pending4", {31'd0, busy1}, 32'd1);
    chk("fill_idx17", rdata2, 32'd17);
    sweep_run(1'b1);
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      chk("cleared_reg", rdata1, 32'h0);
      chk("cleared_pend", {31'd0, busy2}, 32'd0);
    end

    // Reset asserted mid-sweep.
    wr0(5'd30, 32'h0000_001E, 4'hF);
    tick();
    idle_in();
    issue_valid = 1'b1; issue_addr = 5'd30;
    tick();
    idle_in();
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    raddr1 = 5'd30;
    #1;
    chk("mid_sweep_busy", {31'd0, clear_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_kills_busy", {31'd0, clear_busy}, 32'd0);
    chk("rst_clears_reg", rdata1, 32'h0);
    chk("rst_clears_pend", {31'd0, busy1}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_no_done", {31'd0, clear_done}, 32'd0);
    end
    reset_n = 1'b1;
    tick();
    wr0(5'd12, 32'h0000_000C, 4'hF);
    tick();
    idle_in();
    raddr1 = 5'd12;
    #1;
    chk("post_rst_write", rdata1, 32'h0000_000C);
    sweep_run(1'b0);
    #1;
    chk("resweep_cleared", rdata1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
